// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF/ID decoupling queue of {pc, inst} pairs with flush
// Optional perf counters enabled by defining IF_ID_PERF_EN.
module if_id_buffer #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [INST_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0] out_inst,
   input  logic              flush,
   output logic [CNT_W-1:0]  count,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   localparam int PTR_W = (CNT_W > 1) ? CNT_W - 1 : 1;

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Head is forced to zero (NOP) when empty so decode never sees stale words.
   assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
   assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else if (flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef IF_ID_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   // Refused offers count even during flush; cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (in_valid && !in_ready) stall_q <= stall_q + 32'd1;
         if (flush) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - scoreboard bench for if_id_buffer
module tb_if_id_buffer;

   localparam int DEPTH = 2;
`ifdef IF_ID_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        flush;
   logic [1:0]  count;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   int checks = 0;
   int errors = 0;

   logic [63:0] sb[$];
   int unsigned exp_stall = 0;
   int unsigned exp_flush = 0;

   if_id_buffer #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .flush(flush), .count(count), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return 32'h3401_0000 ^ (pc * 32'h0101);
   endfunction

   // Advance one edge; the model decides from its own pre-edge state.
   task automatic step();
      bit m_ready;
      bit m_valid;
      m_ready = (sb.size() < DEPTH);
      m_valid = (sb.size() != 0);
      if (in_valid && !m_ready) exp_stall++;
      if (flush) exp_flush++;
      @(posedge clk);
      if (flush) begin
         sb.delete();
      end else begin
         if (m_valid && out_ready) void'(sb.pop_front());
         if (in_valid && m_ready) sb.push_back({in_pc, in_inst});
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 2'd0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b count=%0d, required 1 0 0", in_ready, out_valid, count);
      end
      checks++;
      if (out_inst !== 32'h0 || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: pc=%h inst=%h, required 0 0", out_pc, out_inst);
      end
      checks++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_perf: stall=%0d flush=%0d, required 0 0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_single_pass();
      in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'h3401_1100; out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_no_bypass: out_valid=%b, required 0", out_valid);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || {out_pc, out_inst} !== sb[0]) begin
         errors++;
         $display("FAIL single_out: valid=%b pc=%h inst=%h, required 1 %h", out_valid, out_pc, out_inst, sb[0]);
      end
      step();
      checks++;
      if (count !== 2'(sb.size()) || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: count=%0d valid=%b, required %0d 0", count, out_valid, sb.size());
      end
   endtask

   task automatic test_fill_stall();
      int unsigned stall_base;
      stall_base = exp_stall;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_pc = (i < 2) ? 32'(i * 4) : 32'h8;
         in_inst = inst_of(in_pc);
         step();
      end
      checks++;
      if (count !== 2'd2 || in_ready !== 1'b0 || sb.size() != 2) begin
         errors++;
         $display("FAIL fill_full: count=%0d in_ready=%b, required 2 0", count, in_ready);
      end
      checks++;
      if (stall_cnt !== (PERF ? 32'(exp_stall) : 32'd0) || (PERF && exp_stall - stall_base != 2)) begin
         errors++;
         $display("FAIL fill_stall_cnt: stall=%0d, required %0d", stall_cnt, PERF ? exp_stall : 0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (sb.size() == 0 || out_valid !== 1'b1 || {out_pc, out_inst} !== sb[0] || out_pc !== 32'(i * 4)) begin
            errors++;
            $display("FAIL drain_order[%0d]: valid=%b pc=%h, required 1 %h", i, out_valid, out_pc, 32'(i * 4));
         end
         step();
         if (!(sb.size() > 0 && sb[sb.size() - 1][63:32] == 32'h8) && i == 1) begin
            checks++;
            errors++;
            $display("FAIL drain_accept: 0x8 not in model queue after free slot");
         end
         if (i == 1) in_valid = 1'b0;
      end
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0 || stall_cnt !== (PERF ? 32'(exp_stall) : 32'd0)) begin
         errors++;
         $display("FAIL drain_end: count=%0d valid=%b stall=%0d, required 0 0 %0d", count, out_valid, stall_cnt, PERF ? exp_stall : 0);
      end
   endtask

   task automatic test_stream_wrap();
      logic [31:0] exp_seq[$];
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (i < 10) begin
            in_pc = 32'(i * 4);
            in_inst = inst_of(in_pc);
            exp_seq.push_back(in_pc);
         end else begin
            in_valid = 1'b0;
         end
         if (i > 0) begin
            checks++;
            if (sb.size() == 0 || out_valid !== 1'b1 || {out_pc, out_inst} !== sb[0] || out_pc !== exp_seq[0]) begin
               errors++;
               $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h, required pc %h", i, out_valid, out_pc, out_inst, exp_seq[0]);
            end
            void'(exp_seq.pop_front());
            checks++;
            if (count !== 2'd1) begin
               errors++;
               $display("FAIL stream_count[%0d]: count=%0d, required 1", i, count);
            end
         end
         step();
      end
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_end: count=%0d valid=%b, required 0 0", count, out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_pc = 32'h40 + 32'(i * 4);
         in_inst = inst_of(in_pc);
         step();
      end
      checks++;
      if (count !== 2'd2) begin
         errors++;
         $display("FAIL flush_pre: count=%0d, required 2", count);
      end
      flush = 1'b1; in_pc = 32'h100; in_inst = inst_of(32'h100); out_ready = 1'b1;
      step();
      checks++;
      if (count !== 2'(sb.size()) || out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0) begin
         errors++;
         $display("FAIL flush_clear: count=%0d valid=%b ready=%b, required 0 0 1", count, out_valid, in_ready);
      end
      checks++;
      if (flush_cnt !== (PERF ? 32'(exp_flush) : 32'd0)) begin
         errors++;
         $display("FAIL flush_cnt1: flush_cnt=%0d, required %0d", flush_cnt, PERF ? exp_flush : 0);
      end
      step();
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL flush_held: count=%0d valid=%b pc=%h, required 0 0 0", count, out_valid, out_pc);
      end
      checks++;
      if (flush_cnt !== (PERF ? 32'(exp_flush) : 32'd0)) begin
         errors++;
         $display("FAIL flush_cnt3: flush_cnt=%0d, required %0d", flush_cnt, PERF ? exp_flush : 0);
      end
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; in_pc = 32'h200; in_inst = inst_of(32'h200); out_ready = 1'b0;
      step();
      in_valid = 1'b1; in_pc = 32'h204;
      checks++;
      if (count !== 2'd1 || out_pc !== 32'h200) begin
         errors++;
         $display("FAIL areset_pre: count=%0d pc=%h, required 1 200", count, out_pc);
      end
      #2;
      rst = 1'b0;
      #1;
      sb.delete();
      exp_stall = 0;
      exp_flush = 0;
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL areset_now: valid=%b count=%0d pc=%h ready=%b, required 0 0 0 1", out_valid, count, out_pc, in_ready);
      end
      checks++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         errors++;
         $display("FAIL areset_perf: stall=%0d flush=%0d, required 0 0", stall_cnt, flush_cnt);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      step();
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL areset_after: count=%0d valid=%b, required 0 0", count, out_valid);
      end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
      out_ready = 1'b0; flush = 1'b0;
      test_reset();
      test_single_pass();
      test_fill_stall();
      test_stream_wrap();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
